// File: rtl/sdram_ctrl.sv
// sdram_ctrl: single-requester controller for a x16, 4-bank SDRAM
// (13-bit row, 10-bit column). Runs power-up init and mode-register
// programming, turns single-word read/write requests into
// ACT / READ|WRITE / BST / PRE sequences and, optionally, schedules
// periodic auto-refresh.
//
// Optional feature macro: SDRAM_REFRESH_EN enables the periodic refresh
// timer. Without it, REF is issued only during init.
//
// Ports:
//   clk, rst              clock (posedge) and async active-high reset
//   req_valid/req_ready   request handshake
//   req_we                1 = write, 0 = read
//   req_addr              {ba[24:23], row[22:10], col[9:0]}
//   req_wdata             write data
//   rsp_valid             one-cycle pulse: read data valid or write done
//   rsp_rdata             last read data (held until the next read)
//   init_done             init sequence complete
//   dram_*                registered SDRAM pins; dram_dq driven only for WRITE
module sdram_ctrl #(
    parameter int INIT_CYCLES    = 5000,
    parameter int TRCD_CYCLES    = 2,
    parameter int TRP_CYCLES     = 2,
    parameter int TRFC_CYCLES    = 7,
    parameter int REFRESH_CYCLES = 390
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [24:0] req_addr,
    input  logic [15:0] req_wdata,
    output logic        rsp_valid,
    output logic [15:0] rsp_rdata,
    output logic        init_done,
    output logic [12:0] dram_addr,
    output logic [1:0]  dram_ba,
    output logic        dram_ras_n,
    output logic        dram_cas_n,
    output logic        dram_we_n,
    inout  wire  [15:0] dram_dq
);

    // {ras_n, cas_n, we_n}
    localparam logic [2:0] C_NOP = 3'b111, C_ACT = 3'b011, C_RD  = 3'b101,
                           C_WR  = 3'b100, C_BST = 3'b110, C_PRE = 3'b010,
                           C_REF = 3'b001, C_MRS = 3'b000;

    typedef enum logic [3:0] {
        S_INIT_WAIT, S_INIT_PRE, S_INIT_REF1, S_INIT_REF2, S_INIT_MRS,
        S_IDLE, S_RCD, S_WR, S_CAS, S_BST, S_PRE_WAIT, S_REF_WAIT
    } state_t;

    state_t      state;
    logic [15:0] cnt;
    logic [2:0]  cmd;
    logic        dq_oe;
    logic        we_q;
    logic [9:0]  col_q;
    logic [15:0] wdata_q;
    logic        refresh_pending;
    logic        pending_nxt;
    logic        cnt_zero;

    assign cnt_zero = (cnt == 16'd0);
    assign {dram_ras_n, dram_cas_n, dram_we_n} = cmd;
    assign dram_dq = dq_oe ? wdata_q : 16'hzzzz;

`ifdef SDRAM_REFRESH_EN
    logic [15:0] ref_cnt;
    logic        expire;
    logic        ref_done;

    assign expire   = init_done && (ref_cnt == 16'(REFRESH_CYCLES - 1));
    assign ref_done = (state == S_REF_WAIT) && cnt_zero;
    // A second expiry while pending simply keeps the flag set (merged).
    assign pending_nxt = expire | (refresh_pending & ~ref_done);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ref_cnt         <= 16'd0;
            refresh_pending <= 1'b0;
        end else if (!init_done) begin
            ref_cnt         <= 16'd0;
            refresh_pending <= 1'b0;
        end else begin
            ref_cnt         <= expire ? 16'd0 : ref_cnt + 16'd1;
            refresh_pending <= pending_nxt;
        end
    end
`else
    assign refresh_pending = 1'b0;
    assign pending_nxt     = 1'b0;
`endif

    // Every wait state counts cnt down to zero and acts on the zero cycle,
    // so loading N-1 places the next command N edges later.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= S_INIT_WAIT;
            cnt       <= 16'(INIT_CYCLES);
            cmd       <= C_NOP;
            dram_addr <= 13'h0;
            dram_ba   <= 2'h0;
            dq_oe     <= 1'b0;
            req_ready <= 1'b0;
            rsp_valid <= 1'b0;
            rsp_rdata <= 16'h0;
            init_done <= 1'b0;
            we_q      <= 1'b0;
            col_q     <= 10'h0;
            wdata_q   <= 16'h0;
        end else begin
            cmd       <= C_NOP;
            rsp_valid <= 1'b0;
            if (!cnt_zero) cnt <= cnt - 16'd1;
            case (state)
                S_INIT_WAIT: if (cnt_zero) begin
                    cmd       <= C_PRE;
                    dram_addr <= 13'h400;            // A10: all banks
                    cnt       <= 16'(TRP_CYCLES - 1);
                    state     <= S_INIT_PRE;
                end
                S_INIT_PRE: if (cnt_zero) begin
                    cmd   <= C_REF;
                    cnt   <= 16'(TRFC_CYCLES - 1);
                    state <= S_INIT_REF1;
                end
                S_INIT_REF1: if (cnt_zero) begin
                    cmd   <= C_REF;
                    cnt   <= 16'(TRFC_CYCLES - 1);
                    state <= S_INIT_REF2;
                end
                S_INIT_REF2: if (cnt_zero) begin
                    cmd       <= C_MRS;
                    dram_addr <= 13'h037;            // full page, sequential, CL3
                    dram_ba   <= 2'h0;
                    cnt       <= 16'd2;              // two NOPs before IDLE
                    state     <= S_INIT_MRS;
                end
                S_INIT_MRS: if (cnt_zero) begin
                    init_done <= 1'b1;
                    req_ready <= ~pending_nxt;
                    state     <= S_IDLE;
                end
                S_IDLE: begin
                    if (refresh_pending) begin
                        cmd       <= C_REF;
                        cnt       <= 16'(TRFC_CYCLES - 1);
                        req_ready <= 1'b0;
                        state     <= S_REF_WAIT;
                    end else if (req_valid && req_ready) begin
                        cmd       <= C_ACT;
                        dram_ba   <= req_addr[24:23];
                        dram_addr <= req_addr[22:10];
                        we_q      <= req_we;
                        col_q     <= req_addr[9:0];
                        wdata_q   <= req_wdata;
                        req_ready <= 1'b0;
                        cnt       <= 16'(TRCD_CYCLES - 1);
                        state     <= S_RCD;
                    end else begin
                        // Drop ready on the same edge refresh becomes pending
                        // so a refresh always wins over a later request.
                        req_ready <= ~pending_nxt;
                    end
                end
                S_RCD: if (cnt_zero) begin
                    dram_addr <= {3'b000, col_q};    // A10=0: no auto-precharge
                    if (we_q) begin
                        cmd   <= C_WR;
                        dq_oe <= 1'b1;
                        state <= S_WR;
                    end else begin
                        cmd   <= C_RD;
                        cnt   <= 16'd2;              // capture on the CL3 edge
                        state <= S_CAS;
                    end
                end
                S_WR: begin
                    dq_oe     <= 1'b0;
                    cmd       <= C_PRE;
                    dram_addr <= 13'h0;
                    rsp_valid <= 1'b1;
                    cnt       <= 16'(TRP_CYCLES - 1);
                    state     <= S_PRE_WAIT;
                end
                S_CAS: if (cnt_zero) begin
                    // Full-page burst is cut off right at the captured word.
                    rsp_rdata <= dram_dq;
                    rsp_valid <= 1'b1;
                    cmd       <= C_BST;
                    state     <= S_BST;
                end
                S_BST: begin
                    cmd       <= C_PRE;
                    dram_addr <= 13'h0;
                    cnt       <= 16'(TRP_CYCLES - 1);
                    state     <= S_PRE_WAIT;
                end
                S_PRE_WAIT, S_REF_WAIT: if (cnt_zero) begin
                    req_ready <= ~pending_nxt;
                    state     <= S_IDLE;
                end
                default: state <= S_INIT_WAIT;
            endcase
        end
    end

endmodule

// File: tb/tb_sdram_ctrl.sv
`timescale 1ns/1ps
module tb_sdram_ctrl;
    localparam int INIT = 10, TRCD = 2, TRP = 2, TRFC = 7, REFC = 20;
    localparam logic [2:0] C_NOP = 3'b111, C_ACT = 3'b011, C_RD  = 3'b101,
                           C_WR  = 3'b100, C_BST = 3'b110, C_PRE = 3'b010,
                           C_REF = 3'b001, C_MRS = 3'b000;

    logic        clk = 1'b0, rst = 1'b1;
    logic        req_valid = 1'b0, req_we = 1'b0;
    logic [24:0] req_addr = 25'h0;
    logic [15:0] req_wdata = 16'h0;
    logic        req_ready, rsp_valid, init_done;
    logic [15:0] rsp_rdata;
    logic [12:0] dram_addr;
    logic [1:0]  dram_ba;
    logic        dram_ras_n, dram_cas_n, dram_we_n;
    wire  [15:0] dram_dq;
    logic        tb_oe = 1'b0;
    logic [15:0] tb_dq = 16'h0;
    wire  [2:0]  cmd = {dram_ras_n, dram_cas_n, dram_we_n};

    assign dram_dq = tb_oe ? tb_dq : 16'hzzzz;

    sdram_ctrl #(.INIT_CYCLES(INIT), .TRCD_CYCLES(TRCD), .TRP_CYCLES(TRP),
                 .TRFC_CYCLES(TRFC), .REFRESH_CYCLES(REFC)) dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
        .req_we(req_we), .req_addr(req_addr), .req_wdata(req_wdata),
        .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .init_done(init_done),
        .dram_addr(dram_addr), .dram_ba(dram_ba), .dram_ras_n(dram_ras_n),
        .dram_cas_n(dram_cas_n), .dram_we_n(dram_we_n), .dram_dq(dram_dq));

    always #5 clk = ~clk;

    int total = 0, passed = 0;
    int cyc = 0;
    always @(posedge clk) cyc++;

    // SDRAM model: commands seen half a cycle after launch; read data is
    // presented so that it is stable across the launch+3 edge.
    logic [12:0] open_row [4];
    logic [15:0] mem [logic [24:0]];
    logic [24:0] rd_a = 25'h0;
    int rd_dly = 0, ref_seen = 0, drive_seen = 0;

    always @(negedge clk) begin
        if (tb_oe) tb_oe = 1'b0;
        if (rd_dly == 1) begin
            tb_dq = mem.exists(rd_a) ? mem[rd_a] : 16'h0000;
            tb_oe = 1'b1;
        end
        if (rd_dly > 0) rd_dly--;
        if (dut.dq_oe) drive_seen++;
        case (cmd)
            C_ACT: open_row[dram_ba] = dram_addr;
            C_RD:  begin rd_a = {dram_ba, open_row[dram_ba], dram_addr[9:0]}; rd_dly = 2; end
            C_WR:  mem[{dram_ba, open_row[dram_ba], dram_addr[9:0]}] = dram_dq;
            C_REF: ref_seen++;
            default: ;
        endcase
    end

    task automatic wait_cmd(output int gap);
        gap = -1;
        for (int i = 1; i <= 200; i++) begin
            @(negedge clk);
            if (cmd !== C_NOP) begin gap = i; break; end
        end
    endtask

    task automatic wait_ready(input int t0, output int dt);
        dt = -1;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (req_ready) begin dt = cyc - t0; break; end
        end
    endtask

    task automatic test_reset();
        int gap;
        rst = 1'b1;
        repeat (2) @(negedge clk);
        total++; if (cmd !== C_NOP) $display("FAIL reset_cmd: got %0h exp %0h", cmd, C_NOP); else passed++;
        total++; if ({dram_addr, dram_ba} !== 15'h0) $display("FAIL reset_addr: got %0h exp 0", {dram_addr, dram_ba}); else passed++;
        total++; if ({req_ready, rsp_valid, init_done} !== 3'b000) $display("FAIL reset_flags: got %b exp 000", {req_ready, rsp_valid, init_done}); else passed++;
        total++; if (rsp_rdata !== 16'h0) $display("FAIL reset_rdata: got %0h exp 0", rsp_rdata); else passed++;
        total++; if (dut.dq_oe !== 1'b0) $display("FAIL reset_dq: got %b exp 0", dut.dq_oe); else passed++;
        drive_seen = 0;
        rst = 1'b0;
        // INIT NOP edges, then PRE on the next one
        wait_cmd(gap);
        total++; if (gap !== INIT + 1) $display("FAIL init_wait: got %0d exp %0d", gap, INIT + 1); else passed++;
        total++; if ({cmd, dram_addr[10]} !== {C_PRE, 1'b1}) $display("FAIL init_pre: got %0h exp %0h", {cmd, dram_addr[10]}, {C_PRE, 1'b1}); else passed++;
        wait_cmd(gap);
        total++; if ({gap[7:0], cmd} !== {8'(TRP), C_REF}) $display("FAIL init_ref1: got %0h exp %0h", {gap[7:0], cmd}, {8'(TRP), C_REF}); else passed++;
        wait_cmd(gap);
        total++; if ({gap[7:0], cmd} !== {8'(TRFC), C_REF}) $display("FAIL init_ref2: got %0h exp %0h", {gap[7:0], cmd}, {8'(TRFC), C_REF}); else passed++;
        wait_cmd(gap);
        total++; if ({gap[7:0], cmd, dram_addr, dram_ba} !== {8'(TRFC), C_MRS, 13'h037, 2'b00}) $display("FAIL init_mrs: got %0h exp %0h", {gap[7:0], cmd, dram_addr, dram_ba}, {8'(TRFC), C_MRS, 13'h037, 2'b00}); else passed++;
        repeat (2) @(negedge clk);
        total++; if (init_done !== 1'b0) $display("FAIL init_early: got %b exp 0", init_done); else passed++;
        @(negedge clk);
        total++; if ({init_done, req_ready} !== 2'b11) $display("FAIL init_done: got %b exp 11", {init_done, req_ready}); else passed++;
        total++; if (drive_seen !== 0) $display("FAIL init_dq: got %0d exp 0", drive_seen); else passed++;
    endtask

    task automatic test_write_read();
        int gap, t0, dt;
        logic [15:0] m;
        // 25'h1ABCDEF -> ba 3, row 13'h0AF3, col 10'h1EF
        req_valid = 1'b1; req_we = 1'b1; req_addr = 25'h1ABCDEF; req_wdata = 16'hBEEF;
        @(negedge clk); t0 = cyc;
        req_valid = 1'b0;
        total++; if ({cmd, dram_ba, dram_addr, req_ready} !== {C_ACT, 2'd3, 13'h0AF3, 1'b0}) $display("FAIL wr_act: got %0h exp %0h", {cmd, dram_ba, dram_addr, req_ready}, {C_ACT, 2'd3, 13'h0AF3, 1'b0}); else passed++;
        wait_cmd(gap);
        total++; if ({gap[7:0], cmd, dram_ba, dram_addr[9:0]} !== {8'(TRCD), C_WR, 2'd3, 10'h1EF}) $display("FAIL wr_cmd: got %0h exp %0h", {gap[7:0], cmd, dram_ba, dram_addr[9:0]}, {8'(TRCD), C_WR, 2'd3, 10'h1EF}); else passed++;
        total++; if (dram_dq !== 16'hBEEF) $display("FAIL wr_dq: got %0h exp beef", dram_dq); else passed++;
        @(negedge clk);
        total++; if ({cmd, dram_addr[10], dram_ba, rsp_valid, dut.dq_oe} !== {C_PRE, 1'b0, 2'd3, 1'b1, 1'b0}) $display("FAIL wr_pre: got %0h exp %0h", {cmd, dram_addr[10], dram_ba, rsp_valid, dut.dq_oe}, {C_PRE, 1'b0, 2'd3, 1'b1, 1'b0}); else passed++;
        @(negedge clk);
        total++; if (rsp_valid !== 1'b0) $display("FAIL wr_pulse: got %b exp 0", rsp_valid); else passed++;
        wait_ready(t0, dt);
        total++; if (dt !== 5) $display("FAIL wr_ready: got %0d exp 5", dt); else passed++;
        m = mem.exists(25'h1ABCDEF) ? mem[25'h1ABCDEF] : 16'h0;
        total++; if (m !== 16'hBEEF) $display("FAIL wr_mem: got %0h exp beef", m); else passed++;

        req_valid = 1'b1; req_we = 1'b0;
        @(negedge clk); t0 = cyc;
        req_valid = 1'b0;
        total++; if ({cmd, dram_ba, dram_addr} !== {C_ACT, 2'd3, 13'h0AF3}) $display("FAIL rd_act: got %0h exp %0h", {cmd, dram_ba, dram_addr}, {C_ACT, 2'd3, 13'h0AF3}); else passed++;
        dt = -1;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            if (rsp_valid) begin dt = cyc - t0; break; end
        end
        // capture/BST edge is ACT + TRCD + 3
        total++; if (dt !== TRCD + 3) $display("FAIL rd_lat: got %0d exp %0d", dt, TRCD + 3); else passed++;
        total++; if (rsp_rdata !== 16'hBEEF) $display("FAIL rd_data: got %0h exp beef", rsp_rdata); else passed++;
        total++; if ({cmd, dram_ba} !== {C_BST, 2'd3}) $display("FAIL rd_bst: got %0h exp %0h", {cmd, dram_ba}, {C_BST, 2'd3}); else passed++;
        @(negedge clk);
        total++; if ({cmd, dram_addr[10], rsp_valid} !== {C_PRE, 1'b0, 1'b0}) $display("FAIL rd_pre: got %0h exp %0h", {cmd, dram_addr[10], rsp_valid}, {C_PRE, 1'b0, 1'b0}); else passed++;
        wait_ready(t0, dt);
        total++; if (dt !== TRCD + 4 + TRP) $display("FAIL rd_ready: got %0d exp %0d", dt, TRCD + 4 + TRP); else passed++;
    endtask

    task automatic test_back_to_back();
        int nact = 0, nrsp = 0, nbst = 0, t1 = 0, t2 = 0, dt;
        logic [15:0] r0 = 16'h0, r1 = 16'h0;
        mem[25'h0] = 16'h1111;
        mem[25'h1] = 16'h2222;
        req_valid = 1'b1; req_we = 1'b0; req_addr = 25'h0;
        for (int i = 0; i < 80 && nrsp < 2; i++) begin
            @(negedge clk);
            if (cmd === C_ACT) begin
                nact++;
                if (nact == 1) begin t1 = cyc; req_addr = 25'h1; end
                else begin t2 = cyc; req_valid = 1'b0; end
            end
            if (rsp_valid) begin
                if (nrsp == 0) r0 = rsp_rdata; else r1 = rsp_rdata;
                nrsp++;
                if (cmd === C_BST) nbst++;
            end
        end
        req_valid = 1'b0;
        total++; if (t2 - t1 !== 9) $display("FAIL b2b_spacing: got %0d exp 9", t2 - t1); else passed++;
        total++; if (nrsp !== 2) $display("FAIL b2b_count: got %0d exp 2", nrsp); else passed++;
        total++; if ({r0, r1} !== {16'h1111, 16'h2222}) $display("FAIL b2b_order: got %0h exp 11112222", {r0, r1}); else passed++;
        total++; if (nbst !== 2) $display("FAIL b2b_bst: got %0d exp 2", nbst); else passed++;
        wait_ready(cyc, dt);
        total++; if (dt < 0) $display("FAIL b2b_ready: got %0d exp >=0", dt); else passed++;
    endtask

    task automatic test_idle();
        ref_seen = 0;
        repeat (1000) @(negedge clk);
`ifdef SDRAM_REFRESH_EN
        total++; if (ref_seen < 49 || ref_seen > 51) $display("FAIL idle_ref: got %0d exp 49..51", ref_seen); else passed++;
`else
        total++; if (ref_seen !== 0) $display("FAIL idle_ref: got %0d exp 0", ref_seen); else passed++;
`endif
        total++; if (init_done !== 1'b1) $display("FAIL idle_done: got %b exp 1", init_done); else passed++;
        while (!req_ready) @(negedge clk);
    endtask

`ifdef SDRAM_REFRESH_EN
    task automatic test_refresh();
        int nact = 0, nrsp = 0, nref = 0, viol = 0, win = 0, last = -1, maxgap = 0;
        req_valid = 1'b1; req_we = 1'b0; req_addr = 25'h10;
        for (int i = 0; i < 240; i++) begin
            @(negedge clk);
            if (i == 220) req_valid = 1'b0;
            if (cmd === C_ACT) begin nact++; req_addr = req_addr + 25'h1; end
            if (rsp_valid) nrsp++;
            if (cmd === C_REF) begin
                nref++;
                if (req_ready) viol++;
                if (last >= 0 && cyc - last > maxgap) maxgap = cyc - last;
                last = cyc;
                win = TRFC - 1;
            end else if (win > 0) begin
                if (req_ready) viol++;
                win--;
            end
        end
        req_valid = 1'b0;
        total++; if (nref < 8) $display("FAIL ref_count: got %0d exp >=8", nref); else passed++;
        total++; if (viol !== 0) $display("FAIL ref_ready: got %0d exp 0", viol); else passed++;
        total++; if (maxgap > REFC + 9) $display("FAIL ref_gap: got %0d exp <=%0d", maxgap, REFC + 9); else passed++;
        total++; if (nact !== nrsp || nact == 0) $display("FAIL ref_lost: got %0d rsp exp %0d", nrsp, nact); else passed++;
    endtask
`endif

    task automatic test_reset_mid();
        int gap, bad = 0;
        req_valid = 1'b1; req_we = 1'b0; req_addr = 25'h5;
        @(negedge clk);
        req_valid = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b1;
        #1;
        total++; if ({cmd, dram_addr, dram_ba} !== {C_NOP, 13'h0, 2'h0}) $display("FAIL rstmid_pins: got %0h exp %0h", {cmd, dram_addr, dram_ba}, {C_NOP, 13'h0, 2'h0}); else passed++;
        total++; if ({req_ready, rsp_valid, init_done, dut.dq_oe} !== 4'b0000) $display("FAIL rstmid_flags: got %b exp 0000", {req_ready, rsp_valid, init_done, dut.dq_oe}); else passed++;
        total++; if (rsp_rdata !== 16'h0) $display("FAIL rstmid_rdata: got %0h exp 0", rsp_rdata); else passed++;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            if (rsp_valid || dut.dq_oe) bad++;
        end
        rst = 1'b0;
        gap = -1;
        for (int i = 1; i <= 40; i++) begin
            @(negedge clk);
            if (rsp_valid || dut.dq_oe) bad++;
            if (cmd !== C_NOP) begin gap = i; break; end
        end
        total++; if ({gap[7:0], cmd} !== {8'(INIT + 1), C_PRE}) $display("FAIL rstmid_restart: got %0h exp %0h", {gap[7:0], cmd}, {8'(INIT + 1), C_PRE}); else passed++;
        for (int i = 0; i < 40 && !init_done; i++) begin
            @(negedge clk);
            if (rsp_valid || dut.dq_oe) bad++;
        end
        total++; if (init_done !== 1'b1) $display("FAIL rstmid_reinit: got %b exp 1", init_done); else passed++;
        total++; if (bad !== 0) $display("FAIL rstmid_quiet: got %0d exp 0", bad); else passed++;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout exp finish");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_write_read();
        test_back_to_back();
        test_idle();
        test_reset_mid();
`ifdef SDRAM_REFRESH_EN
        test_refresh();
`endif
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
